// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional macro CTRL_RETIRE_CNT_EN adds the retire_cnt output counting completed instructions.
module multicycle_ctrl_fsm #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            zero,
    output logic            PCWrite,
    output logic            AdrSrc,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ALUControl,
    output logic            RegWrite,
    output logic [1:0]      ImmSrc
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [XLEN-1:0] retire_cnt
`endif
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    logic [3:0] state_q, state_d;
    logic [3:0] out_state;
    logic       pc_update, branch, reg_write, mem_write, ir_write, adr_src;
    logic [1:0] alu_op;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // While reset is held the outputs show FETCH, so the datapath muxes are already settled on release.
    assign out_state = rst ? S_FETCH : state_q;

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        adr_src   = 1'b0;
        alu_op    = 2'b00;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (out_state)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite  = ~rst & (pc_update | (branch & zero));
    assign IRWrite  = ~rst & ir_write;
    assign MemWrite = ~rst & mem_write;
    assign RegWrite = ~rst & reg_write;
    assign AdrSrc   = adr_src;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [XLEN-1:0] retire_cnt_q;
    logic            retiring;

    // Only completion states count; the illegal-op DECODE->FETCH path is deliberately excluded.
    assign retiring = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                      (state_q == S_ALUWB) || (state_q == S_BEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retiring) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    localparam logic [31:0] XLEN_BITS = XLEN;
    logic unused_xlen;
    assign unused_xlen = XLEN_BITS[0];
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected output vectors queued and compared.
module tb_multicycle_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUControl;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic       rw;
        logic [1:0] imm;
    } out_t;

    typedef struct {
        logic       rst;
        logic       zero;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        out_t       exp;
        string      tag;
    } entry_t;

    entry_t sb[$];
    out_t   obs;
    int     n_tests = 0;
    int     n_fail  = 0;

    assign obs = '{PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, RegWrite, ImmSrc};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

    function automatic out_t mk(logic pcw, logic adr, logic mw, logic irw, logic [1:0] res,
                                logic [1:0] sa, logic [1:0] sbv, logic [2:0] alu, logic rw,
                                logic [1:0] imm);
        out_t o;
        o = '{pcw, adr, mw, irw, res, sa, sbv, alu, rw, imm};
        return o;
    endfunction

    // Expected per-state output vectors, written straight from the state table.
    function automatic out_t e_fetch(logic [1:0] i);  return mk(1,0,0,1,2'b10,2'b00,2'b10,3'b000,0,i); endfunction
    function automatic out_t e_rst(logic [1:0] i);    return mk(0,0,0,0,2'b10,2'b00,2'b10,3'b000,0,i); endfunction
    function automatic out_t e_decode(logic [1:0] i); return mk(0,0,0,0,2'b00,2'b01,2'b01,3'b000,0,i); endfunction
    function automatic out_t e_memadr(logic [1:0] i); return mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,i); endfunction
    function automatic out_t e_memrd(logic [1:0] i);  return mk(0,1,0,0,2'b00,2'b00,2'b00,3'b000,0,i); endfunction
    function automatic out_t e_memwb(logic [1:0] i);  return mk(0,0,0,0,2'b01,2'b00,2'b00,3'b000,1,i); endfunction
    function automatic out_t e_memwr(logic [1:0] i);  return mk(0,1,1,0,2'b00,2'b00,2'b00,3'b000,0,i); endfunction
    function automatic out_t e_execr(logic [2:0] a);  return mk(0,0,0,0,2'b00,2'b10,2'b00,a,0,2'b00); endfunction
    function automatic out_t e_execi(logic [2:0] a);  return mk(0,0,0,0,2'b00,2'b10,2'b01,a,0,2'b00); endfunction
    function automatic out_t e_aluwb(logic [1:0] i);  return mk(0,0,0,0,2'b00,2'b00,2'b00,3'b000,1,i); endfunction
    function automatic out_t e_beq(logic z);          return mk(z,0,0,0,2'b00,2'b10,2'b00,3'b001,0,2'b10); endfunction
    function automatic out_t e_jal();                 return mk(1,0,0,0,2'b00,2'b01,2'b10,3'b000,0,2'b11); endfunction

    function automatic void push(logic r, logic z, logic [6:0] o, logic [2:0] f3v, logic f7v,
                                 out_t e, string t);
        entry_t en;
        en.rst = r; en.zero = z; en.op = o; en.f3 = f3v; en.f7 = f7v; en.exp = e; en.tag = t;
        sb.push_back(en);
    endfunction

    task automatic test_reset();
        rst = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (obs !== e_rst(2'b00)) begin
                n_fail++;
                $display("FAIL reset.cycle%0d got=%h want=%h", i, obs, e_rst(2'b00));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_lw_sw();
        push(0,0,LW,3'b010,0, e_fetch(2'b00),  "lw.FETCH");
        push(0,0,LW,3'b010,0, e_decode(2'b00), "lw.DECODE");
        push(0,0,LW,3'b010,0, e_memadr(2'b00), "lw.MEMADR");
        push(0,0,LW,3'b010,0, e_memrd(2'b00),  "lw.MEMREAD");
        push(0,0,LW,3'b010,0, e_memwb(2'b00),  "lw.MEMWB");
        push(0,0,SW,3'b010,0, e_fetch(2'b01),  "sw.FETCH");
        push(0,0,SW,3'b010,0, e_decode(2'b01), "sw.DECODE");
        push(0,0,SW,3'b010,0, e_memadr(2'b01), "sw.MEMADR");
        push(0,0,SW,3'b010,0, e_memwr(2'b01),  "sw.MEMWRITE");
        while (sb.size() > 0) begin
            entry_t e = sb.pop_front();
            rst = e.rst; zero = e.zero; op = e.op; funct3 = e.f3; funct7b5 = e.f7;
            #1;
            n_tests++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        // R-type sub, I-type add (funct7b5 ignored for immediates), then slt/or/and.
        push(0,0,RT,3'b000,1, e_fetch(2'b00),  "sub.FETCH");
        push(0,0,RT,3'b000,1, e_decode(2'b00), "sub.DECODE");
        push(0,0,RT,3'b000,1, e_execr(3'b001), "sub.EXECR");
        push(0,0,RT,3'b000,1, e_aluwb(2'b00),  "sub.ALUWB");
        push(0,0,IT,3'b000,1, e_fetch(2'b00),  "addi.FETCH");
        push(0,0,IT,3'b000,1, e_decode(2'b00), "addi.DECODE");
        push(0,0,IT,3'b000,1, e_execi(3'b000), "addi.EXECI");
        push(0,0,IT,3'b000,1, e_aluwb(2'b00),  "addi.ALUWB");
        push(0,0,RT,3'b010,0, e_fetch(2'b00),  "slt.FETCH");
        push(0,0,RT,3'b010,0, e_decode(2'b00), "slt.DECODE");
        push(0,0,RT,3'b010,0, e_execr(3'b101), "slt.EXECR");
        push(0,0,RT,3'b010,0, e_aluwb(2'b00),  "slt.ALUWB");
        push(0,0,IT,3'b110,0, e_fetch(2'b00),  "ori.FETCH");
        push(0,0,IT,3'b110,0, e_decode(2'b00), "ori.DECODE");
        push(0,0,IT,3'b110,0, e_execi(3'b011), "ori.EXECI");
        push(0,0,IT,3'b110,0, e_aluwb(2'b00),  "ori.ALUWB");
        push(0,0,RT,3'b111,0, e_fetch(2'b00),  "and.FETCH");
        push(0,0,RT,3'b111,0, e_decode(2'b00), "and.DECODE");
        push(0,0,RT,3'b111,0, e_execr(3'b010), "and.EXECR");
        push(0,0,RT,3'b111,0, e_aluwb(2'b00),  "and.ALUWB");
        while (sb.size() > 0) begin
            entry_t e = sb.pop_front();
            rst = e.rst; zero = e.zero; op = e.op; funct3 = e.f3; funct7b5 = e.f7;
            #1;
            n_tests++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq_jal();
        push(0,1,BQ,3'b000,0, e_fetch(2'b10),  "beqT.FETCH");
        push(0,1,BQ,3'b000,0, e_decode(2'b10), "beqT.DECODE");
        push(0,1,BQ,3'b000,0, e_beq(1'b1),     "beqT.BEQ");
        push(0,0,BQ,3'b000,0, e_fetch(2'b10),  "beqN.FETCH");
        push(0,0,BQ,3'b000,0, e_decode(2'b10), "beqN.DECODE");
        push(0,0,BQ,3'b000,0, e_beq(1'b0),     "beqN.BEQ");
        push(0,0,JL,3'b000,0, e_fetch(2'b11),  "jal.FETCH");
        push(0,0,JL,3'b000,0, e_decode(2'b11), "jal.DECODE");
        push(0,0,JL,3'b000,0, e_jal(),         "jal.JAL");
        push(0,0,JL,3'b000,0, e_aluwb(2'b11),  "jal.ALUWB");
        push(0,0,BAD,3'b000,0, e_fetch(2'b00), "ill.FETCH");
        push(0,0,BAD,3'b000,0, e_decode(2'b00),"ill.DECODE");
        while (sb.size() > 0) begin
            entry_t e = sb.pop_front();
            rst = e.rst; zero = e.zero; op = e.op; funct3 = e.f3; funct7b5 = e.f7;
            #1;
            n_tests++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        // The lw is abandoned in MEMADR; the FETCH afterwards proves the state returned there.
        push(0,0,LW,3'b010,0, e_fetch(2'b00),  "rmid.FETCH");
        push(0,0,LW,3'b010,0, e_decode(2'b00), "rmid.DECODE");
        push(1,0,LW,3'b010,0, e_rst(2'b00),    "rmid.RST");
        push(0,0,LW,3'b010,0, e_fetch(2'b00),  "rmid.FETCH2");
        push(0,0,LW,3'b010,0, e_decode(2'b00), "rmid.DECODE2");
        push(0,0,LW,3'b010,0, e_memadr(2'b00), "rmid.MEMADR2");
        push(0,0,LW,3'b010,0, e_memrd(2'b00),  "rmid.MEMREAD2");
        push(0,0,LW,3'b010,0, e_memwb(2'b00),  "rmid.MEMWB2");
        while (sb.size() > 0) begin
            entry_t e = sb.pop_front();
            rst = e.rst; zero = e.zero; op = e.op; funct3 = e.f3; funct7b5 = e.f7;
            #1;
            n_tests++;
            if (obs !== e.exp) begin
                n_fail++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.exp);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

`ifdef CTRL_RETIRE_CNT_EN
    task automatic test_retire();
        logic [31:0] base;
        rst = 1'b1; op = RT; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (retire_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL retire.reset got=%0d want=0", retire_cnt);
        end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (retire_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL retire.rtype got=%0d want=1", retire_cnt);
        end
        base = 32'd1;
        op = BAD;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (retire_cnt !== base) begin
            n_fail++;
            $display("FAIL retire.illegal got=%0d want=%0d", retire_cnt, base);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw_sw();
        test_alu();
        test_beq_jal();
        test_reset_mid();
`ifdef CTRL_RETIRE_CNT_EN
        test_retire();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control unit for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the instruction-register load strobe (IRWrite), PC update, memory, register-file and datapath mux selects.
- Decodes op, funct3 and funct7b5 from the latched instruction word.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
XLEN, 32, width of the retire counter (optional feature only)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
op  in  7  Instr[6:0]
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
zero  in  1  ALU zero flag, valid during BEQ state
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=Result
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register and OldPC load strobe
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RegWrite  out  1  register file write enable
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J

Behaviour:
- State register: 4 bits. Encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10
  - Codes 11-15 are unreachable and return to FETCH.
- Reset:
  - rst=1 at a clock edge loads FETCH.
  - While rst=1, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs follow FETCH values.
  - Reset mid-instruction abandons the instruction with no further writes.
- Transitions:
  - FETCH -> DECODE unconditionally.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH (executes as a NOP: no register or memory write, PC already advanced)
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD -> MEMWB.
  - EXECR, EXECI, JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- Per-state outputs (unlisted enables 0, unlisted selects 00):
  - FETCH: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1
  - DECODE: SrcA=01, SrcB=01, ALUOp=00
  - MEMADR: SrcA=10, SrcB=01, ALUOp=00
  - MEMREAD: ResultSrc=00, AdrSrc=1
  - MEMWB: ResultSrc=01, RegWrite=1
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1
  - EXECR: SrcA=10, SrcB=00, ALUOp=10
  - EXECI: SrcA=10, SrcB=01, ALUOp=10
  - ALUWB: ResultSrc=00, RegWrite=1
  - BEQ: SrcA=10, SrcB=00, ALUOp=01, ResultSrc=00, Branch=1
  - JAL: SrcA=01, SrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1
- PCWrite = PCUpdate | (Branch & zero). This is the only output that depends on a datapath input.
- ALUControl from ALUOp:
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if (op[5] & funct7b5), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other funct3 -> add
- ImmSrc is combinational from op in every state: sw=01, beq=10, jal=11, else 00.
- Cycle counts: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.

Optional Feature:
CTRL_RETIRE_CNT_EN
- Defined:
  - Adds output retire_cnt [XLEN-1:0], reset to 0.
  - Increments by 1 on each clock edge where the state leaves MEMWB, MEMWRITE, ALUWB or BEQ into FETCH.
  - Illegal-op DECODE->FETCH does not count.
  - Wraps from all-ones to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset held 2 cycles, then released with op=0000011:
  - IRWrite=0 during reset.
  - Cycle 1: IRWrite=1, PCWrite=1, ALUSrcB=10.
  - Sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5.
- op=0100011: MemWrite=1, AdrSrc=1 in cycle 4, then FETCH; RegWrite never 1.
- op=0110011, funct3=000, funct7b5=1: ALUControl=001 in EXECR.
  - Repeat with op=0010011: ALUControl=000.
  - funct3=010 gives 101.
- op=1100011 in BEQ: zero=1 -> PCWrite=1; zero=0 -> PCWrite=0; next state FETCH either way.
- op=1101111: JAL has PCWrite=1, SrcA=01, SrcB=10; ALUWB has RegWrite=1; ImmSrc=11 throughout.
- op=1111111: DECODE returns to FETCH with no write strobe.
  - rst pulsed during MEMADR of lw: next state FETCH, MemWrite=0, RegWrite=0.
  - With CTRL_RETIRE_CNT_EN, retire_cnt increments 0->1 after an R-type and is unchanged after the illegal op.
